// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader shared definitions.
// Default widths and the sequencer state encoding.
package ram_stream_reader_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 11;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_stream_reader_fifo2.sv
// ram_rd_fifo2: two-entry FIFO of {last, data} words.
// Entry 0 is always the head; pop is taken combinationally.
module ram_rd_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'(FIFO_DEPTH)) || pop_ok);

  assign dout  = ent0;
  assign valid = (cnt != 2'd0);
  assign count = cnt;

  // Shift-register storage: head in ent0, second word in ent1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst read sequencer for a registered-read RAM.
// Issues reads, absorbs the read latency and emits a valid/ready stream.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              zero_done_q;

  logic              issue;
  logic              drain_done;
  logic              pop;
  logic              accept;
  logic              last_issue;
  logic [2:0]        occ;
  logic [2:0]        occ_limit;

  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_dout;

  assign accept     = (state == IDLE) && start;
  assign last_issue = (rem_q == LEN_W'(1));
  assign pop        = fifo_valid && m_ready;

  // Words held or owed to the FIFO; a pop this cycle frees one slot.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign occ_limit = 3'd2 + {2'b00, pop};

  assign ram_en   = issue;
  assign ram_addr = addr_q;
  assign ram_rst  = rst;

  assign m_valid = fifo_valid;
  assign m_data  = fifo_dout[DATA_W-1:0];
  assign m_last  = fifo_valid && fifo_dout[DATA_W];

  assign busy = (state != IDLE) || zero_done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, read issue and burst completion.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    drain_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (len != '0)) state_nxt = READ;
      end
      READ: begin
        if (occ < occ_limit) begin
          issue = 1'b1;
          if (last_issue) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done = drain_done || zero_done_q;

  // Address, remaining count and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      zero_done_q <= accept && (len == '0);
      inflight_q  <= issue;
      if (issue) inflight_last_q <= last_issue;
      if (accept) begin
        addr_q <= base_addr;
        rem_q  <= len;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
    end
  end

  ram_rd_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  ({inflight_last_q, ram_dout}),
    .pop  (pop),
    .dout (fifo_dout),
    .valid(fifo_valid),
    .count(fifo_count)
  );

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read sequencer that sits directly downstream of the 1024x16 single-port block RAM. It accepts a burst command of base address and length, and issues `en`/`addr` read requests to the RAM. It absorbs the RAM's one-cycle registered-read latency and presents the words as a valid/ready stream with a last-beat flag. A 2-entry output buffer gives full throughput under continuous `m_ready` and no data loss under backpressure.

## Interface
- `ADDR_W`, 10, RAM address width; address arithmetic wraps mod 2^ADDR_W
- `DATA_W`, 16, RAM/stream data width
- `LEN_W`, 11, burst length width; legal lengths 0..2^ADDR_W
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe; sampled only in IDLE
- `base_addr`  in  ADDR_W  first RAM address of the burst
- `len`  in  LEN_W  number of words to read
- `busy`  out  1  high from the cycle after an accepted start until the cycle `done` pulses (inclusive)
- `done`  out  1  one-cycle pulse when the burst completes
- `ram_en`  out  1  RAM read enable; one RAM read per cycle in which it is high
- `ram_addr`  out  ADDR_W  RAM address
- `ram_rst`  out  1  RAM output reset; equals `rst`
- `ram_dout`  in  DATA_W  RAM registered read data, valid the cycle after `ram_en`
- `m_valid`  out  1  stream beat valid
- `m_ready`  in  1  stream beat accepted when `m_valid && m_ready`
- `m_data`  out  DATA_W  stream data
- `m_last`  out  1  high on the final beat of a burst

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: on `start`, latch `base_addr` into the address register and `len` into the remaining counter.
  - `len != 0`: go to READ.
  - `len == 0`: pulse `done` next cycle and stay in IDLE. No `ram_en`, no beats.
- `start` outside IDLE is ignored.
- READ: assert `ram_en` when (fifo occupancy + in-flight reads − pop this cycle) < 2.
  - On each issue: address += 1 (wrap 2^ADDR_W−1 → 0) and remaining −= 1.
  - The read issued with remaining == 1 carries the last tag.
  - After the last issue, go to DRAIN.
- In-flight flag: set on issue; the next cycle `ram_dout` and the last tag are pushed into the FIFO.
- DRAIN: when the FIFO is empty and no read is in flight, pulse `done`, deassert `busy`, and return to IDLE.
  - Equivalently, `done` coincides with the cycle after the `m_last` beat handshakes.
- `ram_en` is never high outside READ. `ram_addr` holds its value when not issuing.
- `m_data` and `m_last` are stable while `m_valid && !m_ready`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `ram_en`, `m_valid`, `m_last` = 0; `ram_addr` = 0; `m_data` = 0; FIFO empty; in-flight clear.
- `start` high in cycle t gives:
  - `busy` and first `ram_en` in t+1
  - `ram_dout` valid in t+2
  - first `m_valid` in t+3
- With `m_ready` held high, a burst of N words has `m_valid` high in cycles t+3..t+N+2 and `done` in t+N+3.
- Backpressure: at most 2 words are buffered. Issue stalls within the same cycle so that no RAM word is ever dropped.
- `rst` mid-burst: the next cycle is in reset state. In-flight RAM data is discarded and `done` is not pulsed.
- Simultaneous push and pop on a full FIFO is legal; occupancy stays unchanged.

## Structure
- Shared package holds `ADDR_W`/`DATA_W`/`LEN_W` defaults and the state enum (IDLE, READ, DRAIN).
- One sub-module: `ram_rd_fifo2`, a 2-entry FIFO of {last, data} with push/pop/count.
  - Pop is combinational on `m_valid && m_ready`.
  - Push and pop in the same cycle are allowed.

## Test plan
- `start`, `base_addr`=0x010, `len`=4, RAM[0x10..0x13]=A0..A3, `m_ready`=1 -> beats A0..A3 in cycles t+3..t+6, `m_last` only on A3, `done` at t+7.
- `base_addr`=0x3FE, `len`=4 -> `ram_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001; data matches.
- `len`=8, `m_ready` toggled 1/0 every cycle (plus 5-cycle stall mid-burst) -> all 8 words delivered in order, none duplicated, `m_data` stable during stalls, FIFO never exceeds 2.
- `len`=0 -> `done` pulse at t+1, no `ram_en`, no `m_valid`; `start` pulsed while `busy` -> ignored.
- `len`=1024 from 0 with `m_ready`=1 -> 1024 beats back-to-back, `done` at t+1027.
- `rst` asserted mid-burst (after 3 beats) -> all outputs at reset values next cycle; a new start afterwards runs cleanly.
